bbb_array_emulator: RTL and testbench

//  Transmit-side model of the BeagleBone microphone-array shield. Generates pdm_clk and

---
 rtl/bbb_array_pkg.sv | 21 ++
 rtl/bbb_array_emulator_if.sv | 26 ++
 rtl/bbb_pdm_clkgen.sv | 70 +++++++
 rtl/bbb_array_emulator.sv | 78 +++++++
 tb/tb_bbb_array_emulator.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bbb_array_pkg.sv
// Shared types and default geometry for the BeagleBone microphone-array emulator and adapter.
package bbb_array_pkg;

    localparam int DEF_NUM_ROWS = 5;
    localparam int DEF_NUM_COLS = 8;
    localparam int DEF_CLK_DIV  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    typedef logic [DEF_NUM_COLS-1:0][DEF_NUM_ROWS-1:0] frame_t;

    // A full column scan must finish before the next pdm_clk edge.
    function automatic bit clk_div_ok(input int clk_div, input int num_cols);
        return clk_div >= num_cols + 2;
    endfunction

endpackage

// File: rtl/bbb_array_emulator_if.sv
// Bus between the array emulator (master) and whatever consumes its PDM stream (slave).
interface bbb_array_emulator_if #(
    parameter int NUM_ROWS  = 5,
    parameter int NUM_COLS  = 8,
    parameter int SEL_WIDTH = $clog2(NUM_COLS)
);
    logic                               enable;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]  mic_data_r;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0]  mic_data_l;
    logic                               frame_stb;
    logic                               pdm_clk;
    logic                               pulse_lr;
    logic                               lr_phase;
    logic [NUM_ROWS-1:0]                pdm_out;
    logic [SEL_WIDTH-1:0]               sel_out;

    modport master (
        input  enable, mic_data_r, mic_data_l,
        output frame_stb, pdm_clk, pulse_lr, lr_phase, pdm_out, sel_out
    );

    modport slave (
        output enable, mic_data_r, mic_data_l,
        input  frame_stb, pdm_clk, pulse_lr, lr_phase, pdm_out, sel_out
    );
endinterface

// File: rtl/bbb_pdm_clkgen.sv
// PDM clock divider with run/stop sequencing; emits a strobe for every scan-starting edge.
module bbb_pdm_clkgen
    import bbb_array_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic pdm_clk,
    output logic pulse_lr,
    output logic rise_stb,
    output logic scan_stb
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
    logic               pdm_clk_reg, pdm_clk_next;
    logic               wrap;

    assign wrap     = (div_cnt_reg == DIV_W'(CLK_DIV - 1));
    assign pdm_clk  = pdm_clk_reg;
    assign pulse_lr = (state_reg != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            pdm_clk_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            pdm_clk_reg <= pdm_clk_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        pdm_clk_next = pdm_clk_reg;
        rise_stb     = 1'b0;
        scan_stb     = 1'b0;
        case (state_reg)
            IDLE: begin
                div_cnt_next = '0;
                pdm_clk_next = 1'b0;
                if (enable) state_next = RUN;
            end
            RUN: begin
                div_cnt_next = wrap ? '0 : div_cnt_reg + 1'b1;
                if (wrap) begin
                    pdm_clk_next = ~pdm_clk_reg;
                    scan_stb     = 1'b1;
                    rise_stb     = ~pdm_clk_reg;
                end
                if (!enable) state_next = STOP;
            end
            STOP: begin
                // Finish the half period; a high clock drops without starting a left scan.
                div_cnt_next = wrap ? '0 : div_cnt_reg + 1'b1;
                if (wrap) begin
                    pdm_clk_next = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: rtl/bbb_array_emulator.sv
// Transmit-side model of the microphone-array shield: captures a frame per pdm_clk period
// and walks its columns onto the row lines after each pdm_clk edge.
module bbb_array_emulator
    import bbb_array_pkg::*;
#(
    parameter int NUM_ROWS  = DEF_NUM_ROWS,
    parameter int NUM_COLS  = DEF_NUM_COLS,
    parameter int SEL_WIDTH = $clog2(NUM_COLS),
    parameter int CLK_DIV   = DEF_CLK_DIV
) (
    input logic                  clk,
    input logic                  reset_n,
    bbb_array_emulator_if.master bus
);
    generate
        if (!clk_div_ok(CLK_DIV, NUM_COLS)) begin : g_bad_clk_div
            $error("CLK_DIV must be at least NUM_COLS+2");
        end
    endgenerate

    logic pdm_clk, pulse_lr, rise_stb, scan_stb;

    bbb_pdm_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (bus.enable),
        .pdm_clk  (pdm_clk),
        .pulse_lr (pulse_lr),
        .rise_stb (rise_stb),
        .scan_stb (scan_stb)
    );

    logic [NUM_COLS-1:0][NUM_ROWS-1:0] shadow_r_reg, shadow_l_reg;
    logic [SEL_WIDTH:0]                scan_cnt_reg;
    logic [SEL_WIDTH-1:0]              sel_reg, scan_idx;
    logic [NUM_ROWS-1:0]               pdm_out_reg;
    logic                              lr_phase_reg;

    assign scan_idx = SEL_WIDTH'(scan_cnt_reg - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_r_reg <= '0;
            shadow_l_reg <= '0;
            scan_cnt_reg <= '0;
            sel_reg      <= '0;
            pdm_out_reg  <= '0;
            lr_phase_reg <= 1'b0;
        end else begin
            // Both halves are latched at the rise so the left scan is immune to input changes.
            if (rise_stb) begin
                shadow_r_reg <= bus.mic_data_r;
                shadow_l_reg <= bus.mic_data_l;
            end
            if (scan_stb) begin
                scan_cnt_reg <= (SEL_WIDTH+1)'(NUM_COLS);
                lr_phase_reg <= ~pdm_clk;
            end else if (scan_cnt_reg != '0) begin
                pdm_out_reg  <= lr_phase_reg ? shadow_r_reg[scan_idx] : shadow_l_reg[scan_idx];
                sel_reg      <= scan_idx;
                scan_cnt_reg <= scan_cnt_reg - 1'b1;
            end else if (!pulse_lr) begin
                pdm_out_reg  <= '0;
                sel_reg      <= '0;
                lr_phase_reg <= 1'b0;
            end
        end
    end

    assign bus.frame_stb = rise_stb;
    assign bus.pdm_clk   = pdm_clk;
    assign bus.pulse_lr  = pulse_lr;
    assign bus.lr_phase  = lr_phase_reg;
    assign bus.pdm_out   = pdm_out_reg;
    assign bus.sel_out   = sel_reg;
endmodule

// File: tb/tb_bbb_array_emulator.sv
// Table-driven bench with a receiver model and scoreboard, plus hand-written timing/stop sequences.
module tb_bbb_array_emulator;
    import bbb_array_pkg::*;

    localparam int NR = 5;
    localparam int NC = 8;

    typedef struct {
        frame_t r;
        frame_t l;
        bit     glitch;
    } vec_t;

    typedef struct packed {
        frame_t r;
        frame_t l;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bbb_array_emulator_if #(.NUM_ROWS(NR), .NUM_COLS(NC)) bus ();

    bbb_array_emulator #(
        .NUM_ROWS (NR),
        .NUM_COLS (NC),
        .CLK_DIV  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   n_pushed = 0;
    int   n_frames = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Receiver model: after every pdm_clk edge, the k-th clk carries column NC-k.
    bit     prev_pdm = 1'b0;
    bit     active = 1'b0;
    bit     phase = 1'b0;
    bit     have_r = 1'b0;
    int     k_mon = 0;
    frame_t rx_r, rx_l;

    always @(negedge clk) begin
        if (!reset_n) begin
            active = 1'b0;
            have_r = 1'b0;
        end else if (bus.pdm_clk != prev_pdm && bus.pulse_lr && mon_en) begin
            active = 1'b1;
            k_mon  = 0;
            phase  = bus.pdm_clk;
        end else if (active) begin
            k_mon++;
            if (phase) rx_r[NC-k_mon] = bus.pdm_out;
            else       rx_l[NC-k_mon] = bus.pdm_out;
            if (k_mon == NC) begin
                active = 1'b0;
                if (phase) begin
                    have_r = 1'b1;
                end else if (have_r) begin
                    have_r = 1'b0;
                    n_frames++;
                    if (exp_q.size() == 0) begin
                        check("scoreboard underflow", 64'(1), 64'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        $display("frame %0d: right=%h left=%h", n_frames, rx_r, rx_l);
                        check("right frame", 64'(rx_r), 64'(e.r));
                        check("left frame", 64'(rx_l), 64'(e.l));
                    end
                end
            end
        end
        prev_pdm = bus.pdm_clk;
    end

    task automatic wait_frame_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.frame_stb) begin
                ok = 1'b1;
                return;
            end
        end
        check("frame_stb timeout", 64'(0), 64'(1));
    endtask

    task automatic send(input frame_t r, input frame_t l, input bit glitch);
        bit ok;
        bus.mic_data_r = r;
        bus.mic_data_l = l;
        wait_frame_stb(ok);
        if (!ok) return;
        exp_q.push_back('{r: r, l: l});
        n_pushed++;
        @(posedge clk);
        #1;
        if (glitch) bus.mic_data_l = ~l;
        repeat (20) @(negedge clk);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.pdm_clk, bus.pulse_lr, bus.lr_phase, bus.pdm_out, bus.sel_out, bus.frame_stb});
    endfunction

    initial begin
        bit ok;
        for (int c = 0; c < NC; c++) begin
            vecs[0].r[c] = 5'(c + 1);
            vecs[0].l[c] = ~5'(c + 1);
            vecs[3].r[c] = c[0] ? 5'h15 : 5'h0A;
            vecs[3].l[c] = c[0] ? 5'h0A : 5'h15;
        end
        vecs[0].glitch = 1'b1;
        vecs[1].r = '1; vecs[1].l = '0; vecs[1].glitch = 1'b1;
        vecs[2].r = '0; vecs[2].l = '1; vecs[2].glitch = 1'b0;
        vecs[3].glitch = 1'b1;
        for (int i = 4; i < 8; i++) begin
            vecs[i].r = frame_t'({$urandom(), $urandom()});
            vecs[i].l = frame_t'({$urandom(), $urandom()});
            vecs[i].glitch = i[0];
        end

        bus.enable = 1'b0;
        bus.mic_data_r = '0;
        bus.mic_data_l = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", all_outs(), 64'(0));
        reset_n = 1'b1;

        // Table vectors, then the 100-frame loopback pattern.
        mon_en = 1'b1;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int i = 0; i < 8; i++) send(vecs[i].r, vecs[i].l, vecs[i].glitch);
        for (int f = 0; f < 100; f++) send(vecs[0].r, vecs[0].l, 1'b1);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));
        check("frames received", 64'(n_frames), 64'(n_pushed));
        mon_en = 1'b0;

        // Scan timing over one full pdm_clk period.
        wait_frame_stb(ok);
        @(negedge clk);
        check("rise after frame_stb", 64'(bus.pdm_clk), 64'(1));
        check("frame_stb one cycle", 64'(bus.frame_stb), 64'(0));
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            case (k)
                1:  begin check("sel E+1", 64'(bus.sel_out), 64'(7)); check("lr_phase right", 64'(bus.lr_phase), 64'(1)); end
                8:  check("sel E+8", 64'(bus.sel_out), 64'(0));
                15: begin check("sel E+15", 64'(bus.sel_out), 64'(0)); check("pdm_clk E+15", 64'(bus.pdm_clk), 64'(1)); end
                16: begin check("pdm_clk fall E+16", 64'(bus.pdm_clk), 64'(0)); check("lr_phase left", 64'(bus.lr_phase), 64'(0)); end
                17: check("sel E+17", 64'(bus.sel_out), 64'(7));
                31: begin check("pdm_clk E+31", 64'(bus.pdm_clk), 64'(0)); check("frame_stb E+31", 64'(bus.frame_stb), 64'(1)); end
                32: check("pdm_clk period", 64'(bus.pdm_clk), 64'(1));
                default: ;
            endcase
        end

        // Stop while pdm_clk is high at div_cnt=3.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) bus.enable = 1'b0;
            case (k)
                15: begin check("stop pdm_clk E+15", 64'(bus.pdm_clk), 64'(1)); check("stop pulse_lr E+15", 64'(bus.pulse_lr), 64'(1)); end
                16: begin check("stop pdm_clk fall", 64'(bus.pdm_clk), 64'(0)); check("stop pulse_lr low", 64'(bus.pulse_lr), 64'(0)); end
                17: begin check("stop no left scan", 64'(bus.sel_out), 64'(0)); check("stop pdm_out", 64'(bus.pdm_out), 64'(0)); check("stop lr_phase", 64'(bus.lr_phase), 64'(0)); end
                20: check("stop idle outputs", all_outs(), 64'(0));
                default: ;
            endcase
        end

        // Restart requested during STOP.
        bus.enable = 1'b1;
        wait_frame_stb(ok);
        @(negedge clk);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 3) bus.enable = 1'b0;
            if (k == 5) bus.enable = 1'b1;
            case (k)
                15: check("restart pdm_clk E+15", 64'(bus.pdm_clk), 64'(1));
                16: begin check("restart fall", 64'(bus.pdm_clk), 64'(0)); check("restart idle cycle", 64'(bus.pulse_lr), 64'(0)); end
                17: check("restart run", 64'(bus.pulse_lr), 64'(1));
                32: check("restart pdm_clk before rise", 64'(bus.pdm_clk), 64'(0));
                33: check("restart first rise", 64'(bus.pdm_clk), 64'(1));
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a right scan.
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check("async reset outputs", all_outs(), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 check("idle after release", 64'({bus.pulse_lr, bus.pdm_clk}), 64'(0));
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            case (k)
                1:  check("run after release", 64'(bus.pulse_lr), 64'(1));
                16: check("no resumed frame", 64'(bus.pdm_clk), 64'(0));
                17: check("fresh rise", 64'(bus.pdm_clk), 64'(1));
                default: ;
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
